// File: rtl/myo_spi_scheduler_if.sv
// Register-file inputs, SpiControl handshake and per-motor strobes of the SPI frame scheduler.
// slave = scheduler side, master = register file / SpiControl / consumers side.
interface myo_spi_scheduler_if #(
  parameter int NUMBER_OF_MOTORS = 6
);
  logic                        enable;
  logic [NUMBER_OF_MOTORS-1:0] motor_mask;
  logic [31:0]                 period_cycles;
  logic                        spi_done;
  logic                        start;
  logic [7:0]                  motor;
  logic                        latch;
  logic                        pid_update_valid;
  logic [7:0]                  pid_update;
  logic                        cycle_done;
  logic                        overrun;
  logic [15:0]                 overrun_count;
  logic                        timeout;
  logic                        busy;

  modport slave (
    input  enable, motor_mask, period_cycles, spi_done,
    output start, motor, latch, pid_update_valid, pid_update,
           cycle_done, overrun, overrun_count, timeout, busy
  );

  modport master (
    output enable, motor_mask, period_cycles, spi_done,
    input  start, motor, latch, pid_update_valid, pid_update,
           cycle_done, overrun, overrun_count, timeout, busy
  );
endinterface

// File: rtl/myo_spi_scheduler.sv
// Walks the enabled motors once per control period, one SPI frame each, with watchdog and overrun tracking.
// All outputs registered; done seen at edge E gives latch at E+1, PID strobe at E+2, next start at E+4.
module myo_spi_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input logic                clock,
  input logic                reset,
  myo_spi_scheduler_if.slave sched_io
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SELECT      = 3'd1;
  localparam logic [2:0] S_START       = 3'd2;
  localparam logic [2:0] S_WAIT_ACK    = 3'd3;
  localparam logic [2:0] S_WAIT_DONE   = 3'd4;
  localparam logic [2:0] S_LATCH       = 3'd5;
  localparam logic [2:0] S_UPDATE      = 3'd6;
  localparam logic [2:0] S_PERIOD_WAIT = 3'd7;

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic            first_q, first_d;
  logic [7:0]      motor_q, motor_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [31:0]     period_q, period_d;
  logic [15:0]     ovr_cnt_q, ovr_cnt_d;
  logic            reload;
  logic            cycle_done_d, timeout_d, overrun_d;

  logic            start_q, latch_q, pid_vld_q, cycle_done_q, overrun_q, timeout_q, busy_q;
  logic [7:0]      pid_update_q;

  logic            next_found;
  logic [7:0]      next_idx;

  // Lowest enabled motor, restricted to indices above the current one once the cycle is under way.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUMBER_OF_MOTORS - 1; i >= 0; i--) begin
      if (sched_io.motor_mask[i] && (first_q || (i > int'(motor_q)))) begin
        next_found = 1'b1;
        next_idx   = 8'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    motor_d      = motor_q;
    reload       = 1'b0;
    cycle_done_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sched_io.enable && (|sched_io.motor_mask)) begin
          state_d = S_SELECT;
          first_d = 1'b1;
          reload  = 1'b1;
        end
      end
      S_SELECT: begin
        if (!(|sched_io.motor_mask) || !sched_io.enable) begin
          state_d = S_IDLE;
        end else if (next_found) begin
          motor_d = next_idx;
          state_d = S_START;
        end else begin
          cycle_done_d = 1'b1;
          state_d      = S_PERIOD_WAIT;
        end
      end
      S_START: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!sched_io.spi_done) begin
          state_d = S_WAIT_DONE;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          first_d   = 1'b0;
          state_d   = S_SELECT;
        end
      end
      S_WAIT_DONE: begin
        if (sched_io.spi_done) begin
          state_d = S_LATCH;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          first_d   = 1'b0;
          state_d   = S_SELECT;
        end
      end
      S_LATCH: state_d = S_UPDATE;
      S_UPDATE: begin
        first_d = 1'b0;
        state_d = S_SELECT;
      end
      S_PERIOD_WAIT: begin
        if (!sched_io.enable) begin
          state_d = S_IDLE;
        end else if (period_q < 32'd2) begin
          // Leave one cycle early so consecutive SELECTs land exactly period_cycles apart.
          state_d = S_SELECT;
          first_d = 1'b1;
          reload  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wdog_d = (state_d != state_q) ? '0 : wdog_q + 1'b1;
  end

  always_comb begin
    period_d = period_q;
    if (reload) begin
      period_d = sched_io.period_cycles;
    end else if (period_q != 32'd0) begin
      period_d = period_q - 32'd1;
    end
    overrun_d = (period_q == 32'd1) && (state_q != S_IDLE) && (state_q != S_PERIOD_WAIT);
    ovr_cnt_d = (overrun_d && (ovr_cnt_q != 16'hFFFF)) ? ovr_cnt_q + 16'd1 : ovr_cnt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      first_q      <= 1'b0;
      motor_q      <= '0;
      wdog_q       <= '0;
      period_q     <= '0;
      ovr_cnt_q    <= '0;
      start_q      <= 1'b0;
      latch_q      <= 1'b0;
      pid_vld_q    <= 1'b0;
      pid_update_q <= '0;
      cycle_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      motor_q      <= motor_d;
      wdog_q       <= wdog_d;
      period_q     <= period_d;
      ovr_cnt_q    <= ovr_cnt_d;
      start_q      <= (state_d == S_START);
      latch_q      <= (state_d == S_LATCH);
      pid_vld_q    <= (state_d == S_UPDATE);
      if (state_d == S_UPDATE) begin
        pid_update_q <= motor_q;
      end
      cycle_done_q <= cycle_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign sched_io.start            = start_q;
  assign sched_io.motor            = motor_q;
  assign sched_io.latch            = latch_q;
  assign sched_io.pid_update_valid = pid_vld_q;
  assign sched_io.pid_update       = pid_update_q;
  assign sched_io.cycle_done       = cycle_done_q;
  assign sched_io.overrun          = overrun_q;
  assign sched_io.overrun_count    = ovr_cnt_q;
  assign sched_io.timeout          = timeout_q;
  assign sched_io.busy             = busy_q;

endmodule

// File: doc/myo_spi_scheduler.md
# myo_spi_scheduler

Sequences SPI frame transactions across the motor boards that share one SPI bus. It replaces ad-hoc motor counter logic with an explicit FSM that supports a per-motor enable mask, a fixed control period, transaction timeouts and overrun accounting. The block sits between the Avalon register file (mask, period, enable) and the SpiControl/spi_master pair. It drives the active-motor index that selects slave-select, pwmRef and the latch target, and it strobes the PID update of each serviced motor.

## Interface
- NUMBER_OF_MOTORS, 6: motors on the bus, 1..254
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for a handshake edge from SpiControl
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  scheduling enabled (spi_activated)
- motor_mask  in  NUMBER_OF_MOTORS  bit i=1 → motor i serviced
- period_cycles  in  32  minimum clocks between cycle starts; 0 = free-running
- spi_done  in  1  SpiControl done level; low while a frame is in flight
- start  out  1  one-cycle pulse to SpiControl start
- motor  out  8  active motor index
- latch  out  1  one-cycle pulse: store position/velocity/current/displacement for motor
- pid_update_valid  out  1  one-cycle pulse: update PID of pid_update
- pid_update  out  8  index of motor whose PID is updated
- cycle_done  out  1  one-cycle pulse after the last enabled motor of a cycle
- overrun  out  1  one-cycle pulse when a period expires before its cycle finished
- overrun_count  out  16  saturating overrun counter
- timeout  out  1  one-cycle pulse when a handshake timed out
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, SELECT, START, WAIT_ACK, WAIT_DONE, LATCH, UPDATE, PERIOD_WAIT.
- IDLE: if enable=1 and motor_mask≠0, go to SELECT with first=1, load period counter with period_cycles, and begin the cycle.
- SELECT: samples motor_mask.
  - first=1: motor ← lowest set index.
  - first=0: motor ← lowest set index strictly greater than the current motor.
  - No such index: pulse cycle_done and go to PERIOD_WAIT.
  - Mask zero: go to IDLE.
- START: start=1 for one cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for spi_done=0, then go to WAIT_DONE.
- WAIT_DONE: wait for spi_done=1, then go to LATCH.
- Timeout: each wait state has a watchdog of TIMEOUT_CYCLES. On expiry, pulse timeout, skip this motor (no latch, no PID update), and go to SELECT.
- LATCH: latch=1, motor stable. Go to UPDATE.
- UPDATE: pid_update_valid=1, pid_update=motor. Go to SELECT with first=0.
- PERIOD_WAIT: wait until the period counter reaches 0, then go to IDLE-equivalent cycle start (SELECT with first=1, counter reloaded). With period_cycles=0 this restarts immediately.
- Period counter: decrements every clock while nonzero, independent of state.
  - If it reaches 0 while the FSM is outside PERIOD_WAIT/IDLE, pulse overrun once per period and increment overrun_count, saturating at 16'hFFFF.
  - The next cycle then starts directly after the current one finishes.
- enable falling mid-cycle: the in-flight frame completes (or times out), including LATCH/UPDATE; then go to IDLE. No new start is issued.
- period_cycles and motor_mask changes take effect at the next reload/SELECT. They never abort a frame.
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-frame abandons it without a latch.

## Timing
- All outputs are registered.
- start, latch, pid_update_valid, cycle_done, overrun and timeout are exactly one clock wide.
- Clock edge E samples spi_done=1 in WAIT_DONE:
  - latch is high in cycle E+1.
  - pid_update_valid is high in cycle E+2.
  - Next start is high in cycle E+4 (SELECT at E+3).
- start and latch never occur in the same cycle.
- motor changes only in SELECT.
- After a cycle_done pulse in cycle C (free-running), the next start is in cycle C+2.
- Watchdog counts from entry into the wait state. Expiry on wait cycle TIMEOUT_CYCLES asserts timeout in the next cycle.

## Test plan
- Mask 6'b111111, period 0, SpiControl model acks in 3 cycles and is done 20 cycles later → start/latch/pid_update for motors 0..5 in order, cycle_done after motor 5, repeats, overrun_count stays 0.
- Mask 6'b100101 → service order 0,2,5,0,…; motors 1,3,4 never latched.
- Period 1000, frames 20 cycles long → cycle starts exactly 1000 cycles apart, no overrun. Period 50 → overrun pulse each period, count increments, restart directly after each cycle_done.
- spi_done stuck high for motor 2 → timeout after TIMEOUT_CYCLES, no latch/pid for 2, motor 3 started next.
- Drop enable while motor 1's frame is in flight → latch and pid for motor 1 occur, then busy=0 and no further start.
- Assert reset mid-WAIT_DONE → all outputs 0 next cycle. After release, with enable=1, the first start is for the lowest enabled motor.
